// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants and the buffered fetch entry layout.
package fetch_pkg;

    localparam int unsigned XLEN        = 32;
    localparam logic [31:0] TEXT_BASE   = 32'h0040_0000;
    localparam int unsigned INSTR_BYTES = 4;

    // One buffered fetch result: instruction address and the word read there.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; pointers carry an extra wrap bit for full/empty.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer next-state; flush wins over any push or pop.
    always_comb begin
        do_pop   = pop_i & ~empty_o;
        do_push  = push_i & (~full_o | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push && !flush_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, ROM addressing, range/alignment fault and decode buffer.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC  = DATA_WIDTH'(TEXT_BASE),
    parameter int unsigned          MEM_WORDS  = 1024,
    parameter int unsigned          FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    input  logic                  halt,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rd,
    output logic                  dec_valid,
    input  logic                  dec_ready,
    output logic [DATA_WIDTH-1:0] dec_instr,
    output logic [DATA_WIDTH-1:0] dec_pc,
    output logic                  fault,
    output logic [DATA_WIDTH-1:0] fault_pc,
    output logic [DATA_WIDTH-1:0] retire_count
);

    // One past the last legal byte address, widened so the sum cannot wrap.
    localparam logic [DATA_WIDTH:0] PC_END =
        (DATA_WIDTH+1)'(RESET_PC) + (DATA_WIDTH+1)'(MEM_WORDS * INSTR_BYTES);

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  fault_q, fault_d;
    logic [DATA_WIDTH-1:0] fault_pc_q, fault_pc_d;
    logic [DATA_WIDTH-1:0] retire_q, retire_d;

    logic         pc_bad;
    logic         fetch_en;
    logic         push;
    logic         pop;
    logic         fifo_full;
    logic         fifo_empty;
    fetch_entry_t wr_entry;
    fetch_entry_t rd_entry;

    assign imem_addr    = pc_q;
    assign dec_valid    = ~fifo_empty;
    assign dec_pc       = rd_entry.pc;
    assign dec_instr    = rd_entry.instr;
    assign fault        = fault_q;
    assign fault_pc     = fault_pc_q;
    assign retire_count = retire_q;

    assign wr_entry.pc    = pc_q;
    assign wr_entry.instr = imem_rd;

    // Misaligned, below the text base, or past the end of the ROM.
    assign pc_bad = (pc_q[1:0] != 2'b00) ||
                    (pc_q < RESET_PC) ||
                    ({1'b0, pc_q} >= PC_END);

    assign fetch_en = ~redirect_valid & ~halt & ~fault_q;
    assign pop      = dec_valid & dec_ready;
    assign push     = fetch_en & ~pc_bad & (~fifo_full | pop);

    fetch_fifo #(
        .WIDTH (($bits(fetch_entry_t))),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_valid),
        .push_i  (push),
        .wdata_i (wr_entry),
        .pop_i   (pop & ~redirect_valid),
        .rdata_o (rd_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next PC, fault capture and retire counting; redirect discards the pop.
    always_comb begin
        pc_d       = pc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        retire_d   = retire_q;

        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else begin
            if (push) pc_d = pc_q + DATA_WIDTH'(INSTR_BYTES);
            if (pop)  retire_d = retire_q + DATA_WIDTH'(1);
        end

        if (fetch_en && pc_bad) begin
            fault_d    = 1'b1;
            fault_pc_d = pc_q;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
            retire_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
            retire_q   <= retire_d;
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction ROM: owns the program counter, drives the ROM byte address and captures the instruction word returned in the same cycle.
- The ROM read is combinational and expects text-segment addresses based at 0x0040_0000.
- Fetched {pc, instr} pairs are buffered in a small FIFO and handed to decode over a valid/ready handshake.
- Supports control-flow redirect with flush, a fetch halt, and a sticky fetch fault for misaligned or out-of-range PCs.

Parameters:
- DATA_WIDTH, 32, instruction and address width.
- RESET_PC, 32'h0040_0000, PC after reset; base of the text segment.
- MEM_WORDS, 1024, ROM depth in words; legal PC range is [RESET_PC, RESET_PC + 4*MEM_WORDS).
- FIFO_DEPTH, 2, fetch buffer entries; power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- redirect_valid  in  1  branch/jump taken; load redirect_pc.
- redirect_pc  in  DATA_WIDTH  new fetch byte address.
- halt  in  1  freeze fetch; the buffer keeps draining.
- imem_addr  out  DATA_WIDTH  byte address to the instruction ROM (equals pc).
- imem_rd  in  DATA_WIDTH  ROM read data, combinational from imem_addr.
- dec_valid  out  1  head entry valid.
- dec_ready  in  1  decode accepts the head entry.
- dec_instr  out  DATA_WIDTH  head instruction.
- dec_pc  out  DATA_WIDTH  head instruction address.
- fault  out  1  sticky fetch fault.
- fault_pc  out  DATA_WIDTH  PC that caused the fault.
- retire_count  out  DATA_WIDTH  count of entries handed to decode.

Behaviour:
- Reset (synchronous, rst=1 at the edge) loads:
  - pc = RESET_PC; FIFO emptied; dec_valid = 0; dec_instr = 0; dec_pc = 0.
  - fault = 0; fault_pc = 0; retire_count = 0.
- rst overrides all other inputs. Reset during a pending redirect or while faulted returns to the reset state.
- imem_addr = pc, combinationally, at all times.
- pop = dec_valid & dec_ready. Each pop increments retire_count, wrapping modulo 2^32.
- push condition: !redirect_valid & !halt & !fault & !pc_bad & (!full | pop).
  - On push at the clock edge: FIFO writes {pc, imem_rd}; pc = pc + 4 (wraps modulo 2^32).
  - Simultaneous push and pop when full is legal; occupancy is unchanged.
  - Simultaneous push and pop when empty: the pop is not possible because dec_valid = 0. No bypass exists; fetch-to-dec_valid latency is 1 cycle.
- pc_bad is true when any of the following holds:
  - pc[1:0] != 0
  - pc < RESET_PC
  - pc >= RESET_PC + 4*MEM_WORDS
- When pc_bad holds with !redirect_valid & !halt & !fault:
  - At the edge, fault = 1 and fault_pc = pc; no push.
  - The fault stays set until rst. Existing FIFO entries still drain.
- Redirect takes priority over push and pop. At the edge with redirect_valid = 1:
  - FIFO is flushed to empty; any same-cycle pop is discarded and retire_count does not increment.
  - pc = redirect_pc.
  - The first instruction at the target shows dec_valid two cycles after the redirect cycle.
- A redirect while faulted still loads pc and flushes, but fault stays set and fetch stays blocked.
- halt = 1: pc and pushes are frozen; pops continue. A redirect while halted still loads pc and flushes.
- dec_valid = !empty. dec_instr and dec_pc come from the head entry and stay stable while dec_valid & !dec_ready.
- FIFO uses read/write pointers with one extra wrap bit:
  - full when the pointers differ only in the MSB;
  - empty when the pointers are equal.

Decomposition:
- Shared package `fetch_pkg` holds:
  - TEXT_BASE = 32'h0040_0000
  - INSTR_BYTES = 4
  - a fetch-entry struct {pc, instr}
- One natural sub-module: `fetch_fifo`, a parameterised synchronous FIFO with flush, push/pop, full/empty, and simultaneous push+pop when full.
- PC register, range check and fault logic stay in instr_fetch_unit.

Test Plan:
- Reset, then dec_ready=1 for 4 cycles -> imem_addr steps 0x400000, 0x400004, …; dec_pc = 0x400000, 0x400004, 0x400008 with dec_instr equal to ROM words 0, 1, 2; retire_count = 3.
- dec_ready=0 for 5 cycles -> FIFO fills to 2 entries, pc holds at 0x400008, dec_pc stable at 0x400000. Then dec_ready=1 -> in-order delivery, no loss or duplication.
- Redirect to 0x400040 on a cycle with dec_valid & dec_ready -> that pop is discarded, the FIFO is flushed, and the next dec_valid shows dec_pc = 0x400040 two cycles later.
- Redirect to 0x400042 -> next cycle fault=1, fault_pc=0x400042, no further pushes. A redirect to 0x400100 keeps fault=1. rst clears everything and fetch restarts at 0x400000.
- Redirect to 0x400FFC with dec_ready=1 -> dec_pc=0x400FFC is delivered, then fault=1 with fault_pc=0x401000.
- halt=1 with 2 entries buffered and dec_ready=1 -> both entries drain, pc is unchanged, dec_valid=0 afterwards. Release halt -> fetch resumes at the held pc.
